// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs symbolic DP/MEM/BRANCH requests into
// 32-bit machine words and writes them sequentially into IMEM.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_cmd,
  input  logic              in_imm,
  input  logic              in_s,
  input  logic              in_load,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow
);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_MEM = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;
  localparam logic [1:0] KIND_END = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, state_next;

  logic        accept;
  logic        full;
  logic        is_word;
  logic        do_write;
  logic        do_overflow;
  logic        do_restart;
  logic [3:0]  cmd4;
  logic [31:0] enc_word;

  assign in_ready    = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign accept      = in_valid & in_ready;
  assign full        = (count == DEPTH_CNT);
  assign is_word     = (in_kind != KIND_END);
  assign do_write    = accept & is_word & ~full;
  assign do_overflow = accept & is_word & full;

  always_comb begin
    state_next = state;
    do_restart = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept && (!is_word || full)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          do_restart = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ALU command codes as the decoder expects them in bits [24:21]
  always_comb begin
    cmd4 = 4'b0100;
    case (in_cmd)
      2'b00:   cmd4 = 4'b0100;
      2'b01:   cmd4 = 4'b0010;
      2'b10:   cmd4 = 4'b0000;
      2'b11:   cmd4 = 4'b1100;
      default: cmd4 = 4'b0100;
    endcase
  end

  // MEM words are always immediate-offset, pre-indexed, add, word, no writeback
  always_comb begin
    enc_word = 32'h0;
    case (in_kind)
      KIND_DP:  enc_word = {in_cond, 2'b00, in_imm, cmd4, in_s, in_rn, in_rd, in_src2};
      KIND_MEM: enc_word = {in_cond, 2'b01, 5'b01100, in_load, in_rn, in_rd, in_src2};
      KIND_BR:  enc_word = {in_cond, 4'b1010, in_imm24};
      default:  enc_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_next;
      imem_we <= do_write;
      if (do_write) begin
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= enc_word;
        count      <= count + CNT_ONE;
      end
      if (do_restart) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (do_overflow) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: unit 0 uses the default depth, unit 1
// a 4-word memory to exercise the overflow boundary.
module tb_instr_encoder;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [1:0]  cmd;
    logic        imm;
    logic        s;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        valid [2];
  logic        start [2];
  req_t        req   [2];
  logic        ready_o [2];
  logic        we_o    [2];
  logic        done_o  [2];
  logic        ovf_o   [2];
  logic [31:0] wdata_o [2];
  logic [5:0]  a0;
  logic [1:0]  a1;
  logic [6:0]  c0;
  logic [2:0]  c1;
  int          addr_o [2];
  int          cnt_o  [2];

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  always_comb begin
    addr_o[0] = int'(a0);
    addr_o[1] = int'(a1);
    cnt_o[0]  = int'(c0);
    cnt_o[1]  = int'(c1);
  end

  instr_encoder #(.ADDR_W(6), .DEPTH(64)) dut0 (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .in_valid(valid[0]), .in_ready(ready_o[0]),
    .in_kind(req[0].kind), .in_cond(req[0].cond), .in_cmd(req[0].cmd),
    .in_imm(req[0].imm), .in_s(req[0].s), .in_load(req[0].load),
    .in_rn(req[0].rn), .in_rd(req[0].rd), .in_src2(req[0].src2),
    .in_imm24(req[0].imm24),
    .imem_we(we_o[0]), .imem_addr(a0), .imem_wdata(wdata_o[0]),
    .count(c0), .done(done_o[0]), .overflow(ovf_o[0])
  );

  instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut1 (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .in_valid(valid[1]), .in_ready(ready_o[1]),
    .in_kind(req[1].kind), .in_cond(req[1].cond), .in_cmd(req[1].cmd),
    .in_imm(req[1].imm), .in_s(req[1].s), .in_load(req[1].load),
    .in_rn(req[1].rn), .in_rd(req[1].rd), .in_src2(req[1].src2),
    .in_imm24(req[1].imm24),
    .imem_we(we_o[1]), .imem_addr(a1), .imem_wdata(wdata_o[1]),
    .count(c1), .done(done_o[1]), .overflow(ovf_o[1])
  );

  // Behavioural model: running flag, word counter and the last expected write
  int          depth   [2] = '{64, 4};
  bit          m_run   [2];
  int          m_count [2];
  bit          m_ovf   [2];
  bit          m_we    [2];
  int          m_addr  [2];
  logic [31:0] m_wdata [2];

  function automatic logic [31:0] model_word(input req_t r);
    int unsigned code [4] = '{4, 2, 0, 12};
    int unsigned w;
    w = 32'(r.cond) << 28;
    if (r.kind == 2'd0)
      w = w | (32'(r.imm) << 25) | (code[r.cmd] << 21) | (32'(r.s) << 20)
            | (32'(r.rn) << 16) | (32'(r.rd) << 12) | 32'(r.src2);
    else if (r.kind == 2'd1)
      w = w | (1 << 26) | (1 << 24) | (1 << 23) | (32'(r.load) << 20)
            | (32'(r.rn) << 16) | (32'(r.rd) << 12) | 32'(r.src2);
    else
      w = w | (32'hA << 24) | 32'(r.imm24);
    return w;
  endfunction

  task automatic model_step(input int u);
    if (rst[u]) begin
      m_run[u] = 1'b1; m_count[u] = 0; m_ovf[u] = 1'b0; m_we[u] = 1'b0;
    end else begin
      m_we[u] = 1'b0;
      if (m_run[u]) begin
        if (valid[u]) begin
          if (req[u].kind == 2'd3) begin
            m_run[u] = 1'b0;
          end else if (m_count[u] == depth[u]) begin
            m_ovf[u] = 1'b1; m_run[u] = 1'b0;
          end else begin
            m_we[u] = 1'b1; m_addr[u] = m_count[u];
            m_wdata[u] = model_word(req[u]); m_count[u]++;
          end
        end
      end else if (start[u]) begin
        m_run[u] = 1'b1; m_count[u] = 0; m_ovf[u] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle after reset, every output against the model
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        checkOutput($sformatf("u%0d.in_ready", u), 32'(ready_o[u]), 32'(m_run[u]));
        checkOutput($sformatf("u%0d.done", u), 32'(done_o[u]), 32'(!m_run[u]));
        checkOutput($sformatf("u%0d.overflow", u), 32'(ovf_o[u]), 32'(m_ovf[u]));
        checkOutput($sformatf("u%0d.count", u), 32'(cnt_o[u]), 32'(m_count[u]));
        checkOutput($sformatf("u%0d.imem_we", u), 32'(we_o[u]), 32'(m_we[u]));
        if (m_we[u]) begin
          checkOutput($sformatf("u%0d.imem_addr", u), 32'(addr_o[u]), 32'(m_addr[u]));
          checkOutput($sformatf("u%0d.imem_wdata", u), wdata_o[u], m_wdata[u]);
        end
      end
    end
  end

  function automatic req_t dp(input logic [3:0] cond, input logic [1:0] cmd, input logic imm,
                              input logic s, input logic [3:0] rn, input logic [3:0] rd,
                              input logic [11:0] src2);
    req_t r;
    r = '{kind: 2'd0, cond: cond, cmd: cmd, imm: imm, s: s, load: 1'b1, rn: rn, rd: rd,
          src2: src2, imm24: 24'h5A5A5A};
    return r;
  endfunction

  function automatic req_t mem(input logic load, input logic [3:0] rn, input logic [3:0] rd,
                               input logic [11:0] off);
    req_t r;
    r = '{kind: 2'd1, cond: 4'hE, cmd: 2'd3, imm: 1'b1, s: 1'b1, load: load, rn: rn, rd: rd,
          src2: off, imm24: 24'h0};
    return r;
  endfunction

  function automatic req_t br(input logic [3:0] cond, input logic [23:0] imm24);
    req_t r;
    r = '{kind: 2'd2, cond: cond, cmd: 2'd3, imm: 1'b1, s: 1'b1, load: 1'b1, rn: 4'hF, rd: 4'hF,
          src2: 12'hFFF, imm24: imm24};
    return r;
  endfunction

  function automatic req_t endreq();
    req_t r;
    r = '{kind: 2'd3, cond: 4'hE, cmd: 2'd0, imm: 1'b0, s: 1'b0, load: 1'b0, rn: 4'h1, rd: 4'h2,
          src2: 12'h3, imm24: 24'h0};
    return r;
  endfunction

  // Called on a negedge; returns on the negedge after the accepting edge
  task automatic applyStimulus(input int u, input req_t r);
    int n = 0;
    req[u]   = r;
    valid[u] = 1'b1;
    while (ready_o[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("[TB] FAIL u%0d.accept: got no in_ready within 20 cycles required in_ready=1", u);
    end else begin
      @(negedge clk);
    end
    valid[u] = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    valid[0] = 1'b0; valid[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    req[0] = '0; req[1] = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.count", 32'(cnt_o[0]), 32'd0);
    checkOutput("reset.imem_we", 32'(we_o[0]), 32'd0);
    checkOutput("reset.imem_addr", 32'(addr_o[0]), 32'd0);
    checkOutput("reset.imem_wdata", wdata_o[0], 32'h0);
    checkOutput("reset.done", 32'(done_o[0]), 32'd0);
    checkOutput("reset.in_ready", 32'(ready_o[0]), 32'd1);
    armed  = 1'b1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    $display("[TB] unit0: single ADD then back-to-back words");
    applyStimulus(0, dp(4'hE, 2'd0, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005));
    checkOutput("add.we", 32'(we_o[0]), 32'd1);
    checkOutput("add.addr", 32'(addr_o[0]), 32'd0);
    checkOutput("add.wdata", wdata_o[0], 32'hE2821005);
    checkOutput("add.count", 32'(cnt_o[0]), 32'd1);
    applyStimulus(0, dp(4'hE, 2'd1, 1'b1, 1'b1, 4'd3, 4'd3, 12'h001));
    checkOutput("subs.wdata", wdata_o[0], 32'hE2533001);
    applyStimulus(0, dp(4'hE, 2'd3, 1'b0, 1'b0, 4'd4, 4'd4, 12'h005));
    checkOutput("orr.wdata", wdata_o[0], 32'hE1844005);
    checkOutput("orr.addr", 32'(addr_o[0]), 32'd2);
    applyStimulus(0, mem(1'b0, 4'd0, 4'd1, 12'd4));
    checkOutput("str.wdata", wdata_o[0], 32'hE5801004);
    checkOutput("str.addr", 32'(addr_o[0]), 32'd3);
    checkOutput("str.count", 32'(cnt_o[0]), 32'd4);

    $display("[TB] unit0: LDR, idle gap, BRANCH");
    applyStimulus(0, mem(1'b1, 4'd0, 4'd2, 12'd4));
    checkOutput("ldr.wdata", wdata_o[0], 32'hE5902004);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("gap.we", 32'(we_o[0]), 32'd0);
    end
    applyStimulus(0, br(4'hE, 24'hFFFFFE));
    checkOutput("br.wdata", wdata_o[0], 32'hEAFFFFFE);
    checkOutput("br.addr", 32'(addr_o[0]), 32'd5);

    $display("[TB] unit0: END, held request, restart");
    applyStimulus(0, endreq());
    checkOutput("end.we", 32'(we_o[0]), 32'd0);
    checkOutput("end.done", 32'(done_o[0]), 32'd1);
    checkOutput("end.in_ready", 32'(ready_o[0]), 32'd0);
    checkOutput("end.count", 32'(cnt_o[0]), 32'd6);
    req[0]   = dp(4'hE, 2'd2, 1'b0, 1'b0, 4'd5, 4'd6, 12'h007);
    valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("held.we", 32'(we_o[0]), 32'd0);
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checkOutput("start.count", 32'(cnt_o[0]), 32'd0);
    checkOutput("start.done", 32'(done_o[0]), 32'd0);
    @(negedge clk);
    valid[0] = 1'b0;
    checkOutput("restart.addr", 32'(addr_o[0]), 32'd0);
    checkOutput("restart.wdata", wdata_o[0], 32'hE0056007);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checkOutput("start_in_run.count", 32'(cnt_o[0]), 32'd1);

    $display("[TB] unit0: reset coincident with a request");
    rst[0]   = 1'b1;
    req[0]   = dp(4'hE, 2'd0, 1'b1, 1'b0, 4'd1, 4'd1, 12'h001);
    valid[0] = 1'b1;
    @(negedge clk);
    rst[0]   = 1'b0;
    valid[0] = 1'b0;
    checkOutput("rst_req.we", 32'(we_o[0]), 32'd0);
    checkOutput("rst_req.count", 32'(cnt_o[0]), 32'd0);
    checkOutput("rst_req.in_ready", 32'(ready_o[0]), 32'd1);
    @(negedge clk);
    checkOutput("rst_req.we_after", 32'(we_o[0]), 32'd0);

    $display("[TB] unit1: overflow at depth 4");
    applyStimulus(1, dp(4'hE, 2'd0, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005));
    applyStimulus(1, dp(4'hE, 2'd1, 1'b1, 1'b1, 4'd3, 4'd3, 12'h001));
    applyStimulus(1, dp(4'hE, 2'd3, 1'b0, 1'b0, 4'd4, 4'd4, 12'h005));
    applyStimulus(1, mem(1'b0, 4'd0, 4'd1, 12'd4));
    checkOutput("d4.last_addr", 32'(addr_o[1]), 32'd3);
    checkOutput("d4.count", 32'(cnt_o[1]), 32'd4);
    applyStimulus(1, dp(4'hE, 2'd0, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005));
    checkOutput("ovf.we", 32'(we_o[1]), 32'd0);
    checkOutput("ovf.overflow", 32'(ovf_o[1]), 32'd1);
    checkOutput("ovf.done", 32'(done_o[1]), 32'd1);
    checkOutput("ovf.count", 32'(cnt_o[1]), 32'd4);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    checkOutput("ovf_clr.overflow", 32'(ovf_o[1]), 32'd0);
    checkOutput("ovf_clr.count", 32'(cnt_o[1]), 32'd0);

    $display("[TB] unit1: END as fifth request");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, mem(i[0], 4'(i), 4'(i + 1), 12'(4 * i)));
    end
    applyStimulus(1, endreq());
    checkOutput("full_end.done", 32'(done_o[1]), 32'd1);
    checkOutput("full_end.overflow", 32'(ovf_o[1]), 32'd0);
    checkOutput("full_end.count", 32'(cnt_o[1]), 32'd4);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming machine-code encoder: the inverse of the instruction decoder.
- Accepts one symbolic operation per cycle over a valid/ready handshake and packs it into a 32-bit instruction word. The word uses the same Op/Funct/Rn/Rd/Src2 field layout and ALU command codes that the decoder consumes.
- Writes each word sequentially into instruction memory through a registered write port.
- Used by the self-test loader to build programs in IMEM before releasing the core from reset.

Parameters:
- ADDR_W, 6, word-address width of the IMEM write port.
- DEPTH, 64, number of writable words (1..2^ADDR_W).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; restarts the program at word 0 (honoured only in DONE)
- in_valid  input  1  request valid
- in_ready  output  1  request can be accepted this cycle
- in_kind  input  2  00 DP, 01 MEM, 10 BRANCH, 11 END
- in_cond  input  4  condition field, instr[31:28]
- in_cmd  input  2  DP operation: 00 ADD, 01 SUB, 10 AND, 11 ORR
- in_imm  input  1  DP: Src2 is an immediate (I bit)
- in_s  input  1  DP: set flags (S bit)
- in_load  input  1  MEM: 1 LDR, 0 STR
- in_rn  input  4  Rn
- in_rd  input  4  Rd
- in_src2  input  12  DP Src2, or MEM imm12 offset
- in_imm24  input  24  BRANCH word offset
- imem_we  output  1  IMEM write enable
- imem_addr  output  ADDR_W  IMEM word address
- imem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  words written since the last start/reset
- done  output  1  END received, or overflow occurred
- overflow  output  1  a request arrived with DEPTH words already written

Behaviour:
- Reset (synchronous, active-high): state RUN; imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, overflow=0. Reset mid-program discards any pending write; no write occurs in the following cycle.
- States:
  - RUN: in_ready=1.
  - DONE: in_ready=0, done=1.
- Handshake: a request is accepted on a rising edge with in_valid & in_ready. Fields are sampled only at acceptance.
- Write latency: 1 cycle. In the cycle after acceptance of DP/MEM/BRANCH:
  - imem_we=1, imem_addr=count(old), imem_wdata=encoded word;
  - count increments in the same edge as the acceptance.
  - imem_we is 0 in every cycle not following an acceptance.
- Throughput: one request per cycle; back-to-back acceptances yield consecutive addresses.
- Encoding for DP:
  - [31:28]=cond, [27:26]=00, [25]=in_imm
  - [24:21]=cmd4, where ADD=0100, SUB=0010, AND=0000, ORR=1100
  - [20]=in_s, [19:16]=rn, [15:12]=rd, [11:0]=in_src2
- Encoding for MEM:
  - [27:26]=01, [25:20]=0,1,1,0,0,in_load (immediate offset, pre-index, add, word, no writeback)
  - rn, rd, [11:0]=in_src2 as for DP
  - in_imm and in_s are ignored.
- Encoding for BRANCH: [27:24]=1010, [23:0]=in_imm24. Rn, Rd, cmd, imm and s fields are ignored.
- END: accepted, writes nothing, count unchanged; next state DONE.
- Overflow: a DP/MEM/BRANCH request accepted while count==DEPTH is not written, sets overflow=1, and moves to DONE. END accepted while count==DEPTH is normal (no overflow).
- DONE: all requests are held off. start=1 moves to RUN and clears count, done and overflow on the same edge. start is ignored in RUN.
- The count width holds the value DEPTH without wrapping; imem_addr never exceeds DEPTH-1.

Test Plan:
- Reset then DP ADD, cond=E, imm=1, s=0, rn=2, rd=1, src2=0x005 → next cycle imem_we=1, addr=0, wdata=0xE2821005; count=1.
- Back-to-back over 3 cycles:
  - SUBS imm (rn=3, rd=3, src2=1) → 0xE2533001 @1
  - ORR reg (rn=4, rd=4, src2=0x005) → 0xE1844005 @2
  - STR (rn=0, rd=1, src2=4) → 0xE5801004 @3
  - Expect consecutive imem_we pulses and count=4.
- Two further requests:
  - LDR (rn=0, rd=2, src2=4) → 0xE5902004
  - BRANCH cond=E, imm24=0xFFFFFE → 0xEAFFFFFE
  - Hold in_valid low for 2 cycles between them → no imem_we pulses in that gap.
- END after 2 words → no write, done=1, in_ready=0; a valid request while in DONE is held and not written. start pulse → count=0, done=0, and the next word lands at addr 0.
- DEPTH=4: write 4 words, then an ADD request → no write, overflow=1, done=1. Repeat, but send END as the 5th request instead → done=1, overflow=0.
- Assert reset in the same cycle as an accepted request → imem_we=0 the next cycle, count=0, state RUN.
